// File: rtl/feature_streamer_if.sv
// Handshake and data bundle between the host, feature_streamer and the LSTM classifier.
// FEATURE_REPLAY_EN adds the host replay request.
interface feature_streamer_if #(
  parameter int unsigned D_WL = 24
) ();
  logic            load_valid;
  logic [D_WL-1:0] load_data;
  logic            load_ready;
  logic            w_x_en;
  logic            f_in_valid;
  logic [D_WL-1:0] feature_in;
  logic            o_valid;
  logic            result;
  logic            busy;
  logic            frame_done;
  logic            class_out;
`ifdef FEATURE_REPLAY_EN
  logic            replay;
`endif

  // Host / network / classifier side.
  modport master (
`ifdef FEATURE_REPLAY_EN
    output replay,
`endif
    output load_valid, load_data, w_x_en, o_valid, result,
    input  load_ready, f_in_valid, feature_in, busy, frame_done, class_out
  );

  // Streamer side.
  modport slave (
`ifdef FEATURE_REPLAY_EN
    input  replay,
`endif
    input  load_valid, load_data, w_x_en, o_valid, result,
    output load_ready, f_in_valid, feature_in, busy, frame_done, class_out
  );
endinterface

// File: rtl/feature_streamer.sv
// Buffers one TIME_STEP x INPUT_SIZE feature frame and bursts one step per w_x_en request.
// Optional FEATURE_REPLAY_EN adds a DONE state that can replay the stored frame.
module feature_streamer #(
  parameter int unsigned INPUT_SIZE = 26,
  parameter int unsigned TIME_STEP  = 148,
  parameter int unsigned D_WL       = 24
) (
  input logic               clk,
  input logic               rst_n,
  feature_streamer_if.slave bus
);
  localparam int unsigned FRAME_LEN = INPUT_SIZE * TIME_STEP;
  localparam int unsigned PtrW      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned StepW     = $clog2(TIME_STEP + 1);
  localparam int unsigned WcW       = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  localparam logic [PtrW-1:0]  LastAddr = PtrW'(FRAME_LEN - 1);
  localparam logic [PtrW-1:0]  StepSize = PtrW'(INPUT_SIZE);
  localparam logic [WcW-1:0]   LastWord = WcW'(INPUT_SIZE - 1);
  localparam logic [StepW-1:0] LastStep = StepW'(TIME_STEP - 1);

  typedef enum logic [2:0] {
    StLoad,
    StWaitReq,
    StSend,
    StWaitLow,
    StWaitRes,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [StepW-1:0]  step_q, step_d;
  logic [WcW-1:0]    word_q, word_d;
  logic              f_in_valid_q, f_in_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              class_q, class_d;
  logic [D_WL-1:0]   feature_in_q;
  logic [D_WL-1:0]   mem_q [FRAME_LEN];

  logic              wr_en;
  logic              rd_en;
  logic [PtrW-1:0]   rd_addr;

  assign rd_addr = rd_ptr_q + PtrW'(word_q);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    step_d       = step_q;
    word_d       = word_q;
    class_d      = class_q;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (bus.load_valid) begin
          wr_en = 1'b1;
          if (wr_ptr_q == LastAddr) begin
            wr_ptr_d = '0;
            state_d  = StWaitReq;
          end else begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
          end
        end
      end
      StWaitReq: begin
        if (bus.w_x_en) begin
          word_d  = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        // Read data lands in feature_in_q one cycle later, so valid trails the read by one cycle.
        rd_en = 1'b1;
        if (word_q == LastWord) begin
          word_d   = '0;
          rd_ptr_d = rd_ptr_q + StepSize;
          step_d   = step_q + StepW'(1);
          state_d  = (step_q == LastStep) ? StWaitRes : StWaitLow;
        end else begin
          word_d = word_q + WcW'(1);
        end
      end
      StWaitLow: begin
        if (!bus.w_x_en) begin
          state_d = StWaitReq;
        end
      end
      StWaitRes: begin
        if (bus.o_valid) begin
          class_d      = bus.result;
          frame_done_d = 1'b1;
          wr_ptr_d     = '0;
          rd_ptr_d     = '0;
          step_d       = '0;
          word_d       = '0;
`ifdef FEATURE_REPLAY_EN
          state_d      = StDone;
`else
          state_d      = StLoad;
`endif
        end
      end
`ifdef FEATURE_REPLAY_EN
      StDone: begin
        // The word offered with load_valid here is not written; the host re-presents it.
        if (bus.replay) begin
          state_d = StWaitReq;
        end else if (bus.load_valid) begin
          state_d = StLoad;
        end
      end
`endif
      default: state_d = StLoad;
    endcase
  end

  assign f_in_valid_d = rd_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StLoad;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      step_q       <= '0;
      word_q       <= '0;
      f_in_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      class_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      step_q       <= step_d;
      word_q       <= word_d;
      f_in_valid_q <= f_in_valid_d;
      frame_done_q <= frame_done_d;
      class_q      <= class_d;
    end
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      feature_in_q <= '0;
    end else if (rd_en) begin
      feature_in_q <= mem_q[rd_addr];
    end
  end

  assign bus.load_ready = (state_q == StLoad);
  assign bus.busy       = (state_q != StLoad) && (state_q != StDone);
  assign bus.f_in_valid = f_in_valid_q;
  assign bus.feature_in = feature_in_q;
  assign bus.frame_done = frame_done_q;
  assign bus.class_out  = class_q;
endmodule
